// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation sequencer.
// The multiplier status encoding is fixed by the multiplier: 0 means result ready.
package rsa_pkg;

    localparam int W_DEF     = 256;
    localparam int EXP_W_DEF = 256;
    localparam int CW_DEF    = 9;

    localparam logic MM_READY   = 1'b0;
    localparam logic MM_PROCESS = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        BIT,
        MUL_CLR, MUL_RUN, MUL_SETTLE,
        SQR_CHK,
        SQR_CLR, SQR_RUN, SQR_SETTLE,
        FIN_CLR, FIN_RUN, FIN_SETTLE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_CLR,
        HS_RUN,
        HS_SETTLE
    } hs_state_e;

endpackage

// File: rtl/rsa_modexp_ctrl_mm_handshake.sv
// CLR/RUN/SETTLE handshake with the shared Montgomery multiplier, reused for
// every multiply, square and final conversion.
module mm_handshake
    import rsa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic mm_out_ready,
    output logic mm_beg,
    output logic ready_seen,
    output logic cap
);

    hs_state_e state_q, state_d;
    logic      armed_q, armed_d;

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        mm_beg     = 1'b0;
        ready_seen = 1'b0;
        cap        = 1'b0;
        case (state_q)
            HS_IDLE:   if (go) state_d = HS_CLR;
            HS_CLR: begin
                armed_d = 1'b0;
                state_d = HS_RUN;
            end
            HS_RUN: begin
                mm_beg  = 1'b1;
                armed_d = 1'b1;
                // The status still belongs to the previous operation on the first RUN cycle.
                if (armed_q && mm_out_ready == MM_READY) begin
                    ready_seen = 1'b1;
                    state_d    = HS_SETTLE;
                end
            end
            HS_SETTLE: begin
                mm_beg  = 1'b1;
                cap     = 1'b1;
                state_d = HS_IDLE;
            end
            default:   state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left binary exponentiation sequencer: M = Y^d mod N on one shared
// Montgomery multiplier, with a final multiply by 1 to leave Montgomery form.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     y_mont,
    input  logic [W-1:0]     r_mod_n,
    input  logic [EXP_W-1:0] d,
    input  logic [W-1:0]     n,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic [W-1:0]     mm_a,
    output logic [W-1:0]     mm_b,
    output logic [W-1:0]     mm_n,
    output logic             mm_beg,
    input  logic [W-1:0]     mm_out,
    input  logic             mm_out_ready
);

    state_e           state_q, state_d;
    logic [W-1:0]     t_q, t_d, s_q, s_d, nreg_q, nreg_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [CW-1:0]    i_q, i_d;
    logic             go, ready_seen, cap;

    mm_handshake u_hs (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .mm_out_ready (mm_out_ready),
        .mm_beg       (mm_beg),
        .ready_seen   (ready_seen),
        .cap          (cap)
    );

    // NOTE: every variable gets its hold value before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        s_d      = s_q;
        e_d      = e_q;
        i_d      = i_q;
        nreg_d   = nreg_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        go       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                t_d     = r_mod_n;
                s_d     = y_mont;
                e_d     = d;
                nreg_d  = n;
                i_d     = '0;
                state_d = BIT;
            end
            BIT: if (e_q[0]) begin
                a_d     = t_q;
                b_d     = s_q;
                go      = 1'b1;
                state_d = MUL_CLR;
            end else begin
                state_d = SQR_CHK;
            end
            MUL_CLR:    state_d = MUL_RUN;
            MUL_RUN:    if (ready_seen) state_d = MUL_SETTLE;
            MUL_SETTLE: if (cap) begin
                t_d     = mm_out;
                state_d = SQR_CHK;
            end
            // The square after the top exponent bit would never be used.
            SQR_CHK: if (i_q == CW'(EXP_W - 1)) begin
                a_d     = t_q;
                b_d     = W'(1);
                go      = 1'b1;
                state_d = FIN_CLR;
            end else begin
                a_d     = s_q;
                b_d     = s_q;
                go      = 1'b1;
                state_d = SQR_CLR;
            end
            SQR_CLR:    state_d = SQR_RUN;
            SQR_RUN:    if (ready_seen) state_d = SQR_SETTLE;
            SQR_SETTLE: if (cap) begin
                s_d     = mm_out;
                e_d     = e_q >> 1;
                i_d     = i_q + 1'b1;
                state_d = BIT;
            end
            FIN_CLR:    state_d = FIN_RUN;
            FIN_RUN:    if (ready_seen) state_d = FIN_SETTLE;
            FIN_SETTLE: if (cap) begin
                result_d = mm_out;
                state_d  = DONE;
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            s_q      <= '0;
            e_q      <= '0;
            i_q      <= '0;
            nreg_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            s_q      <= s_d;
            e_q      <= e_d;
            i_q      <= i_d;
            nreg_q   <= nreg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign mm_a   = a_q;
    assign mm_b   = b_q;
    assign mm_n   = nreg_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl with a behavioural Montgomery multiplier
// stub (random latency, wrong value on the ready cycle, correct one after).
module tb_rsa_modexp_ctrl;
    import rsa_pkg::*;

    localparam int W     = W_DEF;
    localparam int EXP_W = EXP_W_DEF;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [W-1:0]     y_mont_in, r_mod_n_in, n_in;
    logic [EXP_W-1:0] d_in;
    logic             busy, done, mm_beg, mm_out_ready;
    logic [W-1:0]     result, mm_a, mm_b, mm_n, mm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsa_modexp_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .y_mont       (y_mont_in),
        .r_mod_n      (r_mod_n_in),
        .d            (d_in),
        .n            (n_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mm_a         (mm_a),
        .mm_b         (mm_b),
        .mm_n         (mm_n),
        .mm_beg       (mm_beg),
        .mm_out       (mm_out),
        .mm_out_ready (mm_out_ready)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] nn);
        logic [W+1:0] t;
        t = '0;
        for (int k = 0; k < W; k++) begin
            if (a[k]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, nn};
            t = t >> 1;
        end
        if (t >= {2'b00, nn}) t = t - {2'b00, nn};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] nn);
        logic [2*W-1:0] p, m;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m = p % {{W{1'b0}}, nn};
        return m[W-1:0];
    endfunction

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] nn);
        logic [2*W-1:0] wide, m;
        wide = {x, {W{1'b0}}};
        m    = wide % {{W{1'b0}}, nn};
        return m[W-1:0];
    endfunction

    function automatic logic [W-1:0] golden(input logic [W-1:0] y, input logic [EXP_W-1:0] dd,
                                            input logic [W-1:0] nn);
        logic [W-1:0] r, base;
        r    = W'(1);
        base = y;
        for (int k = 0; k < EXP_W; k++) begin
            if (dd[k]) r = mod_mul(r, base, nn);
            base = mod_mul(base, base, nn);
        end
        return r;
    endfunction

    // ---------------- multiplier stub ----------------
    int stub_cnt, stub_lat;
    int lat_min = 3;
    int lat_max = 6;
    logic [W-1:0] stub_res;

    always @(posedge clk) begin
        if (rst) begin
            stub_cnt     <= 0;
            mm_out_ready <= MM_READY;
            mm_out       <= '0;
        end else if (!mm_beg) begin
            stub_cnt <= 0;
        end else if (stub_cnt == 0) begin
            stub_res     <= mont_mul(mm_a, mm_b, mm_n);
            mm_out_ready <= MM_PROCESS;
            stub_lat     <= $urandom_range(lat_max, lat_min);
            stub_cnt     <= 1;
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == stub_lat) begin
                mm_out_ready <= MM_READY;
                mm_out       <= ~stub_res;
            end else if (stub_cnt == stub_lat + 1) begin
                mm_out <= stub_res;
            end
        end
    end

    // ---------------- protocol monitor (counts, tasks compare) ----------------
    logic [W-1:0] cur_n = '0;
    logic [W-1:0] lat_a, lat_b;
    int  pulses = 0, asym = 0, opnd_viol = 0, hs_viol = 0, mn_viol = 0;
    int  phase = 0;
    bit  prev_beg = 1'b0;

    always @(negedge clk) begin
        if (!busy) begin
            phase <= 0;
        end else begin
            if (mm_n !== cur_n) mn_viol <= mn_viol + 1;
            if (mm_beg && !prev_beg) begin
                pulses <= pulses + 1;
                lat_a  <= mm_a;
                lat_b  <= mm_b;
                if (mm_a !== mm_b) asym <= asym + 1;
                phase  <= 1;
            end else begin
                if (mm_beg && (mm_a !== lat_a || mm_b !== lat_b)) opnd_viol <= opnd_viol + 1;
                case (phase)
                    1: if (!mm_beg) hs_viol <= hs_viol + 1;
                       else if (mm_out_ready == MM_READY) phase <= 2;
                    2: begin
                        if (!mm_beg) hs_viol <= hs_viol + 1;
                        phase <= 3;
                    end
                    3: begin
                        if (mm_beg) hs_viol <= hs_viol + 1;
                        phase <= 0;
                    end
                    default: ;
                endcase
            end
        end
        prev_beg <= mm_beg;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [W-1:0] y, input logic [W-1:0] nn,
                            input logic [EXP_W-1:0] dd);
        cur_n      = nn;
        n_in       = nn;
        d_in       = dd;
        y_mont_in  = to_mont(y, nn);
        r_mod_n_in = to_mont(W'(1), nn);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int cyc;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        y_mont_in = W'(7); r_mod_n_in = W'(3); n_in = W'(13); d_in = '1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (result !== '0)   begin errors++; $display("FAIL reset_result: got %0h want 0", result); end
        checks++; if (mm_beg !== 1'b0) begin errors++; $display("FAIL reset_mm_beg: got %b want 0", mm_beg); end
        checks++;
        if ((mm_a | mm_b | mm_n) !== '0) begin
            errors++; $display("FAIL reset_operands: a=%0h b=%0h n=%0h want 0", mm_a, mm_b, mm_n);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_d3();
        int p0, h0, o0, m0;
        bit seen;
        lat_min = 3; lat_max = 6;
        p0 = pulses; h0 = hs_viol; o0 = opnd_viol; m0 = mn_viol;
        start_op(W'(5), W'(13), EXP_W'(3));
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL d3_busy: got %b want 1", busy); end
        wait_done(20000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL d3_timeout: no done within 20000 cycles"); end
        checks++; if (result !== W'(8)) begin errors++; $display("FAIL d3_result: got %0d want 8", result); end
        start = 1'b1;   // start during the DONE cycle
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL d3_done_width: done still %b", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d3_start_in_done: busy=%b want 0", busy); end
        checks++; if (pulses - p0 != 258) begin errors++; $display("FAIL d3_pulses: got %0d want 258", pulses - p0); end
        checks++;
        if (hs_viol != h0 || opnd_viol != o0 || mn_viol != m0) begin
            errors++; $display("FAIL d3_protocol: hs=%0d opnd=%0d mn=%0d want 0",
                               hs_viol - h0, opnd_viol - o0, mn_viol - m0);
        end
    endtask

    task automatic test_d0();
        int p0, a0;
        bit seen;
        p0 = pulses; a0 = asym;
        start_op(W'(5), W'(13), EXP_W'(0));
        wait_done(20000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL d0_timeout: no done within 20000 cycles"); end
        checks++; if (result !== W'(1)) begin errors++; $display("FAIL d0_result: got %0d want 1", result); end
        checks++; if (pulses - p0 != 256) begin errors++; $display("FAIL d0_pulses: got %0d want 256", pulses - p0); end
        checks++; if (asym - a0 != 1) begin errors++; $display("FAIL d0_non_square_ops: got %0d want 1", asym - a0); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0]     nn, y, exp_r;
        logic [EXP_W-1:0] dd;
        int p0, o0, h0;
        bit seen;
        nn = 256'h7a3f_91c2_5d84_e6b0_1f2e_3d4c_5b6a_7988_c0ff_ee12_3456_789a_bcde_f013_5792_4681;
        y  = 256'h1234_5678_9abc_def0_0fed_cba9_8765_4321_dead_beef_cafe_babe_0123_4567_89ab_cdef;
        dd = 256'hc3a5_96e1_0f0f_5a5a_1248_8421_ffff_0000_7777_3333_aaaa_5555_9c9c_6d6d_e00e_b11d;
        exp_r = golden(y, dd, nn);
        p0 = pulses; o0 = opnd_viol; h0 = hs_viol;
        start_op(y, nn, dd);
        wait_done(30000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL rnd_timeout: no done within 30000 cycles"); end
        checks++; if (result !== exp_r) begin errors++; $display("FAIL rnd_result: got %0h want %0h", result, exp_r); end
        checks++;
        if (pulses - p0 != $countones(dd) + EXP_W) begin
            errors++; $display("FAIL rnd_pulses: got %0d want %0d", pulses - p0, $countones(dd) + EXP_W);
        end
        checks++; if (opnd_viol != o0) begin errors++; $display("FAIL rnd_operand_stable: %0d changes", opnd_viol - o0); end
        checks++; if (hs_viol != h0) begin errors++; $display("FAIL rnd_handshake: %0d violations", hs_viol - h0); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int  dcount;
        bit  seen;
        lat_min = 30; lat_max = 30;
        start_op(W'(5), W'(13), EXP_W'(3));
        repeat (998) @(negedge clk);
        n_in = W'(11); d_in = '1; y_mont_in = W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mm_n !== W'(13)) begin
            errors++; $display("FAIL abort_restart_ignored: busy=%b mm_n=%0d want 1/13", busy, mm_n);
        end
        repeat (3994) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before_rst: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mm_beg !== 1'b0 || result !== '0) begin
            errors++; $display("FAIL abort_reset: busy=%b done=%b mm_beg=%b result=%0h want 0",
                               busy, done, mm_beg, result);
        end
        dcount = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checks++; if (dcount != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses want 0", dcount); end
        lat_min = 3; lat_max = 6;
        start_op(W'(7), W'(11), EXP_W'(5));
        wait_done(20000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL abort_rerun_timeout: no done within 20000 cycles"); end
        checks++; if (result !== W'(10)) begin errors++; $display("FAIL abort_rerun_result: got %0d want 10", result); end
        @(negedge clk);
    endtask

    task automatic test_timing();
        int p0, h0;
        bit seen;
        lat_min = 10; lat_max = 300;
        p0 = pulses; h0 = hs_viol;
        start_op(W'(5), W'(13), EXP_W'(6));
        wait_done(90000, seen);
        checks++; if (!seen) begin errors++; $display("FAIL timing_timeout: no done within 90000 cycles"); end
        checks++; if (result !== W'(12)) begin errors++; $display("FAIL timing_result: got %0d want 12", result); end
        checks++; if (pulses - p0 != 258) begin errors++; $display("FAIL timing_pulses: got %0d want 258", pulses - p0); end
        checks++; if (hs_viol != h0) begin errors++; $display("FAIL timing_capture: %0d violations", hs_viol - h0); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        y_mont_in = '0; r_mod_n_in = '0; n_in = '0; d_in = '0;
        test_reset();
        test_d3();
        test_d0();
        test_random();
        test_abort();
        test_timing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
